aes_block_packer: RTL and testbench
===================================

# aes_block_packer

Word-to-block adapter sitting directly upstream and downstream of the AES cipher core wrapper. It collects four 32-bit input words into one 128-bit state and presents it with the operation code on the core's crypt request handshake. It then accepts the 128-bit result and drains it as four 32-bit output words. The block is single-buffered: one block in flight at a time.

## Interface
- `WordW`, 32: input/output word width; fixed, the only supported value.
- `BlockWords`, 4: words per AES block; fixed.
- `clk_i` in 1: clock, the block's only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_valid_i` in 1: input word valid.
- `in_ready_o` out 1: input word accepted when high with `in_valid_i`.
- `in_data_i` in 32: input word.
- `in_op_i` in 2: cipher op (aes_pkg ciph_op_e encoding), sampled with the first word of a block.
- `crypt_valid_o` out 1: block request to the cipher core.
- `crypt_ack_i` in 1: core accepts the request.
- `crypt_data_o` out 128: assembled state.
- `crypt_op_o` out 2: latched op.
- `res_valid_i` in 1: core result valid.
- `res_ack_o` out 1: result accepted when high with `res_valid_i`.
- `res_data_i` in 128: result state.
- `out_valid_o` out 1: output word valid.
- `out_ready_i` in 1: downstream accepts the word.
- `out_data_o` out 32: output word.
- `busy_o` out 1: high in any state except FILL with a count of 0.

## Operation
- FSM states: FILL, REQ, WAIT, DRAIN. Reset state is FILL, word count 0.
- FILL: `in_ready_o`=1.
  - Each handshake writes word k into state bits [32k+31:32k] and increments the count.
  - `in_op_i` is latched only when k=0.
  - The handshake at k=3 moves the FSM to REQ and resets the count to 0.
- REQ: `crypt_valid_o`=1 with stable `crypt_data_o` and `crypt_op_o` until `crypt_ack_i`; then go to WAIT.
- WAIT: `res_ack_o`=1. On `res_valid_i`, capture `res_data_i` into the same 128-bit register and go to DRAIN.
- Outside WAIT, `res_ack_o`=0 and `res_valid_i` is ignored.
- DRAIN: `out_valid_o`=1 and `out_data_o` = result bits [32k+31:32k].
  - Each `out_ready_i` handshake increments k.
  - The handshake at k=3 returns the FSM to FILL with count 0.
- The word count is 2 bits and wraps naturally. No partial blocks exist: a block is always exactly 4 words.
- Inputs offered during REQ, WAIT or DRAIN stall: `in_ready_o`=0.
- Reset in any state, including mid-fill or mid-drain, discards the buffered data. All control outputs drop on the next edge.

## Timing
- Reset values: `in_ready_o`=1 once out of reset. Zero during reset: `crypt_valid_o`, `res_ack_o`, `out_valid_o`, `busy_o`, `crypt_data_o`, `crypt_op_o`, `out_data_o`.
- All outputs are registered or decoded from the state register only. There are no combinational paths from any `*_i` to any `*_o`.
- 4th input handshake at cycle t: `crypt_valid_o`=1 at t+1.
- `crypt_ack_i` at cycle t: `res_ack_o`=1 at t+1. `crypt_ack_i` in the first REQ cycle is legal.
- Result captured at cycle r: output word 0 is valid at r+1. Back-to-back `out_ready_i` drains one word per cycle.
- 4th output handshake at cycle d: `in_ready_o`=1 at d+1.
- Minimum throughput: 4 + 1 + 1 + 4 cycles per block plus core latency.

## Configuration
- `AES_BLOCK_PACKER_BYTESWAP_EN` defined: every input word is byte-reversed before being stored, and every output word is byte-reversed before `out_data_o`. Example: 32'h00112233 becomes 32'h33221100.
- Macro undefined: words pass unchanged. Timing is identical in both builds.

## Structure
- Shared package `aes_wrap_pkg` holds:
  - the state typedef `packer_state_e` {FILL, REQ, WAIT, DRAIN};
  - `BlockWords`=4;
  - `WordW`=32.
- One sub-module, `aes_word_swap`: combinational 32-bit byte reversal, instantiated on the input and output paths under the macro.

## Test plan
- Reset mid-fill after 2 words, then 4 fresh words → `crypt_data_o` contains only the fresh words; `busy_o`=0 immediately after reset.
- Words 32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233 with op 2'b01 → `crypt_data_o`=128'h00112233445566778899aabbccddeeff and `crypt_op_o`=2'b01, one cycle after the 4th handshake.
- `crypt_ack_i` held low for 10 cycles → `crypt_valid_o` and data stable for all 10 cycles. `res_valid_i` pulsed during REQ → ignored, no capture.
- Core returns 128'h69c4e0d86a7b0430d8cdb78070b4c55a with `out_ready_i` toggling 1,0,1,1,0,1 → words 32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8 in order, none dropped or duplicated.
- `in_valid_i` held high throughout two blocks → `in_ready_o`=0 from REQ until the cycle after the last drain handshake; the second block assembles correctly.
- With `AES_BLOCK_PACKER_BYTESWAP_EN` defined, input 32'h00112233 → stored as 32'h33221100. A result word of 32'h33221100 appears as 32'h00112233 on `out_data_o`.

Source files
------------

// File: rtl/aes_wrap_pkg.sv
// Shared definitions for the AES word/block adapters: word geometry, packer
// FSM state type and a byte-reversal helper.
package aes_wrap_pkg;

  localparam int WordW      = 32;
  localparam int BlockWords = 4;
  localparam int BlockW     = WordW * BlockWords;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } packer_state_e;

  function automatic logic [WordW-1:0] byte_reverse(input logic [WordW-1:0] w);
    logic [WordW-1:0] r;
    r = '0;
    for (int b = 0; b < WordW / 8; b++) begin
      r[8*b +: 8] = w[WordW-8-8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_word_swap.sv
// Combinational byte reversal of one 32-bit word (byte 0 <-> byte 3,
// byte 1 <-> byte 2).
module aes_word_swap
  import aes_wrap_pkg::*;
(
  input  logic [WordW-1:0] data_i,
  output logic [WordW-1:0] data_o
);

  assign data_o = byte_reverse(data_i);

endmodule

// File: rtl/aes_block_packer.sv
// Packs four 32-bit words into one 128-bit AES state, hands it to the cipher
// core, and drains the 128-bit result back out as four words. Single block in
// flight. Optional AES_BLOCK_PACKER_BYTESWAP_EN byte-reverses every word on
// the way in and on the way out.
module aes_block_packer
  import aes_wrap_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WordW-1:0]    in_data_i,
  input  logic [1:0]          in_op_i,
  output logic                crypt_valid_o,
  input  logic                crypt_ack_i,
  output logic [BlockW-1:0]   crypt_data_o,
  output logic [1:0]          crypt_op_o,
  input  logic                res_valid_i,
  output logic                res_ack_o,
  input  logic [BlockW-1:0]   res_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WordW-1:0]    out_data_o,
  output logic                busy_o,
  output packer_state_e       state_o
);

  // Handshakes: a transfer happens on a rising edge where the sender's valid
  // and the receiver's ready/ack are both high. Every ready/ack/valid output
  // here is decoded from registers only, never from an input.

  localparam logic [1:0] LastWord = 2'(BlockWords - 1);

  packer_state_e                      state_q, state_d;
  logic [1:0]                         cnt_q;
  logic [1:0]                         op_q;
  logic [BlockWords-1:0][WordW-1:0]   data_q;
  logic [WordW-1:0]                   in_word;
  logic [WordW-1:0]                   out_word;

`ifdef AES_BLOCK_PACKER_BYTESWAP_EN
  aes_word_swap u_in_swap (
    .data_i (in_data_i),
    .data_o (in_word)
  );

  aes_word_swap u_out_swap (
    .data_i (data_q[cnt_q]),
    .data_o (out_word)
  );
`else
  assign in_word  = in_data_i;
  assign out_word = data_q[cnt_q];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_ready_o    = 1'b0;
    crypt_valid_o = 1'b0;
    res_ack_o     = 1'b0;
    out_valid_o   = 1'b0;
    case (state_q)
      FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i && cnt_q == LastWord) state_d = REQ;
      end
      REQ: begin
        crypt_valid_o = 1'b1;
        if (crypt_ack_i) state_d = WAIT;
      end
      WAIT: begin
        res_ack_o = 1'b1;
        if (res_valid_i) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i && cnt_q == LastWord) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // One register holds the plaintext while filling and the result while
  // draining; the count is shared by both phases and wraps back to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      op_q   <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid_i) begin
            data_q[cnt_q] <= in_word;
            if (cnt_q == 2'd0) op_q <= in_op_i;
            cnt_q <= cnt_q + 2'd1;
          end
        end
        WAIT: begin
          if (res_valid_i) data_q <= res_data_i;
        end
        DRAIN: begin
          if (out_ready_i) cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign crypt_data_o = data_q;
  assign crypt_op_o   = op_q;
  assign out_data_o   = (state_q == DRAIN) ? out_word : '0;
  assign busy_o       = !(state_q == FILL && cnt_q == 2'd0);
  assign state_o      = state_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: transaction-level model checked every
// cycle, plus literal expectations from hand-computed vectors.
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic [1:0]   in_op_i;
  logic         crypt_valid_o;
  logic         crypt_ack_i;
  logic [127:0] crypt_data_o;
  logic [1:0]   crypt_op_o;
  logic         res_valid_i;
  logic         res_ack_o;
  logic [127:0] res_data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  out_data_o;
  logic         busy_o;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aes_block_packer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .in_op_i       (in_op_i),
    .crypt_valid_o (crypt_valid_o),
    .crypt_ack_i   (crypt_ack_i),
    .crypt_data_o  (crypt_data_o),
    .crypt_op_o    (crypt_op_o),
    .res_valid_i   (res_valid_i),
    .res_ack_o     (res_ack_o),
    .res_data_i    (res_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .busy_o        (busy_o),
    .state_o       (state_dbg)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] w);
`ifdef AES_BLOCK_PACKER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // ---------------- model + scoreboard ----------------
  // Per block: words accepted, request taken, result taken, words drained.
  int           m_in_cnt = 0;
  bit           m_req_done = 0;
  bit           m_res_done = 0;
  int           m_out_cnt = 0;
  logic [127:0] m_block = '0;
  logic [1:0]   m_op = '0;
  logic [31:0]  exp_q[$];
  bit           m_live = 0;
  bit           m_rst_prev = 0;

  always @(negedge clk) begin
    bit e_in_ready, e_cv, e_ra, e_ov, e_busy;
    e_in_ready = (m_in_cnt < 4);
    e_cv       = (m_in_cnt == 4) && !m_req_done;
    e_ra       = m_req_done && !m_res_done;
    e_ov       = m_res_done && (m_out_cnt < 4);
    e_busy     = (m_in_cnt != 0);
    if (m_live) begin
      chk("in_ready", 128'(in_ready_o), 128'(e_in_ready));
      chk("crypt_valid", 128'(crypt_valid_o), 128'(e_cv));
      chk("res_ack", 128'(res_ack_o), 128'(e_ra));
      chk("out_valid", 128'(out_valid_o), 128'(e_ov));
      chk("busy", 128'(busy_o), 128'(e_busy));
      if (m_rst_prev) begin
        chk("rst_crypt_data", crypt_data_o, 128'h0);
        chk("rst_crypt_op", 128'(crypt_op_o), 128'h0);
        chk("rst_out_data", 128'(out_data_o), 128'h0);
      end
      if (e_cv) begin
        chk("crypt_data", crypt_data_o, m_block);
        chk("crypt_op", 128'(crypt_op_o), 128'(m_op));
      end
      if (e_ov) begin
        if (exp_q.size() == 0) chk("out_data_queue_empty", 128'(out_data_o), 128'hx);
        else chk("out_data", 128'(out_data_o), 128'(exp_q[0]));
      end
    end
    if (rst_i) begin
      m_in_cnt = 0; m_req_done = 0; m_res_done = 0; m_out_cnt = 0;
      m_block = '0; m_op = '0; exp_q.delete();
      m_live = 1; m_rst_prev = 1;
    end else if (m_live) begin
      m_rst_prev = 0;
      if (e_in_ready && in_valid_i) begin
        m_block[32*m_in_cnt +: 32] = bsw(in_data_i);
        if (m_in_cnt == 0) m_op = in_op_i;
        m_in_cnt++;
      end
      if (e_cv && crypt_ack_i) m_req_done = 1;
      if (e_ra && res_valid_i) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(bsw(res_data_i[32*k +: 32]));
        m_res_done = 1;
      end
      if (e_ov && out_ready_i) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_out_cnt++;
        if (m_out_cnt == 4) begin
          m_in_cnt = 0; m_req_done = 0; m_res_done = 0; m_out_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [1:0] op);
    bit done;
    done = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_op_i    = op;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = in_ready_o;
      tick();
    end
    in_valid_i = 1'b0;
    if (!done) timeout("send_word");
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0]  got_q[$];
  logic [31:0]  lit_words[4];
  logic [127:0] lit_block;
  logic [127:0] lit_block2;
  logic [31:0]  lit_swap_in;
  bit           ready_pat[6];

  initial begin
    bit in_hs, ack, rv, got2;
    int nin, nout;
    logic [31:0] word;

`ifdef AES_BLOCK_PACKER_BYTESWAP_EN
    lit_block   = 128'h33221100_77665544_bbaa9988_ffeeddcc;
    lit_words   = '{32'h5ac5b470, 32'h80b7cdd8, 32'h30047b6a, 32'hd8e0c469};
    lit_block2  = 128'h070707a7_060606a6_050505a5_040404a4;
    lit_swap_in = 32'h33221100;
`else
    lit_block   = 128'h00112233_44556677_8899aabb_ccddeeff;
    lit_words   = '{32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
    lit_block2  = 128'ha7070707_a6060606_a5050505_a4040404;
    lit_swap_in = 32'h00112233;
`endif
    ready_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_op_i = '0;
    crypt_ack_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0; out_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset mid-fill discards the two words already taken.
    send_word(32'h11111111, 2'b10);
    send_word(32'h22222222, 2'b10);
    @(negedge clk);
    chk("busy_mid_fill", 128'(busy_o), 128'h1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", 128'(busy_o), 128'h0);
    chk("in_ready_after_rst", 128'(in_ready_o), 128'h1);
    tick();

    // Four fresh words, op 01.
    send_word(32'hccddeeff, 2'b01);
    send_word(32'h8899aabb, 2'b11);
    send_word(32'h44556677, 2'b11);
    send_word(32'h00112233, 2'b11);
    @(negedge clk);
    chk("lit_crypt_valid", 128'(crypt_valid_o), 128'h1);
    chk("lit_crypt_data", crypt_data_o, lit_block);
    chk("lit_crypt_op", 128'(crypt_op_o), 128'h1);
    tick();

    // Ack withheld for ten REQ cycles; a stray result pulse must be ignored.
    for (int i = 0; i < 9; i++) begin
      res_valid_i = (i == 3);
      res_data_i  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      tick();
    end
    res_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_crypt_data_held", crypt_data_o, lit_block);
    tick();
    crypt_ack_i = 1'b1;
    tick();
    crypt_ack_i = 1'b0;
    @(negedge clk);
    chk("lit_res_ack", 128'(res_ack_o), 128'h1);
    tick();
    tick();
    res_valid_i = 1'b1;
    res_data_i  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    tick();
    res_valid_i = 1'b0;
    res_data_i  = '0;

    // Drain with a stuttering downstream.
    for (int i = 0; i < 6; i++) begin
      out_ready_i = ready_pat[i];
      @(negedge clk);
      if (out_valid_o && out_ready_i) got_q.push_back(out_data_o);
      tick();
    end
    out_ready_i = 1'b0;
    chk("lit_drain_count", 128'(got_q.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_q.size()) chk($sformatf("lit_out_word%0d", k), 128'(got_q[k]), 128'(lit_words[k]));
    end
    @(negedge clk);
    chk("lit_in_ready_after_drain", 128'(in_ready_o), 128'h1);
    tick();

    // Two blocks with in_valid held high and a responsive core/sink.
    word = 32'ha0000000;
    nin = 0; nout = 0; got2 = 0;
    in_valid_i = 1'b1; in_data_i = word; in_op_i = 2'b10; out_ready_i = 1'b1;
    for (int c = 0; c < 300 && nout < 8; c++) begin
      @(negedge clk);
      in_hs = in_ready_o && in_valid_i;
      ack   = crypt_valid_o;
      rv    = res_ack_o;
      if (out_valid_o && out_ready_i) nout++;
      if (crypt_valid_o && nin == 8 && !got2) begin
        chk("lit_block2", crypt_data_o, lit_block2);
        got2 = 1;
      end
      if (in_hs) begin
        nin++;
        word = word + 32'h01010101;
      end
      tick();
      crypt_ack_i = ack;
      res_valid_i = rv;
      res_data_i  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0 ^ {4{word}};
      in_data_i   = word;
      in_valid_i  = (nin < 8);
    end
    if (nout < 8) timeout("two_block_drain");
    if (!got2) timeout("two_block_request");
    in_valid_i = 1'b0; crypt_ack_i = 1'b0; res_valid_i = 1'b0; out_ready_i = 1'b0;
    tick();
    tick();

    // Input word lane mapping (byte order depends on the build).
    send_word(32'h00112233, 2'b00);
    @(negedge clk);
    chk("lit_word0_stored", 128'(crypt_data_o[31:0]), 128'(lit_swap_in));
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
